// File: rtl/subleq_sequencer_if.sv
// rtl/subleq_sequencer_if.sv - memory bus between the SUBLEQ sequencer and its memory
interface subleq_sequencer_if;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - single-instruction SUBLEQ machine, six memory cycles per instruction
module subleq_sequencer (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  subleq_sequencer_if.master        bus,
  output logic [7:0]                PC,
  output logic                      HALT
);

  typedef enum logic [2:0] {FA, FB, FC, RA, RB, EX, HLT} state_t;

  state_t     state, state_nxt;
  logic [7:0] op_a, op_b, op_c, val_a;
  logic [7:0] op_a_nxt, op_b_nxt, op_c_nxt, val_a_nxt;
  logic [7:0] pc_nxt;
  logic       halt_nxt;
  logic [7:0] addr;
  logic       rd, wr;
  logic [7:0] diff;
  logic       taken;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FA;
      PC    <= 8'h00;
      HALT  <= 1'b0;
      op_a  <= 8'h00;
      op_b  <= 8'h00;
      op_c  <= 8'h00;
      val_a <= 8'h00;
    end else if (EN) begin
      state <= state_nxt;
      PC    <= pc_nxt;
      HALT  <= halt_nxt;
      op_a  <= op_a_nxt;
      op_b  <= op_b_nxt;
      op_c  <= op_c_nxt;
      val_a <= val_a_nxt;
    end
  end

  // In EX, mem_rdata holds mem[B] read during RB; the difference is the value written back.
  assign diff  = bus.mem_rdata - val_a;
  assign taken = diff[7] | (diff == 8'h00);

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    halt_nxt  = HALT;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    op_c_nxt  = op_c;
    val_a_nxt = val_a;
    addr      = PC;
    rd        = 1'b0;
    wr        = 1'b0;
    case (state)
      FA: begin
        addr      = PC;
        rd        = 1'b1;
        state_nxt = FB;
      end
      FB: begin
        op_a_nxt  = bus.mem_rdata;
        addr      = PC + 8'd1;
        rd        = 1'b1;
        state_nxt = FC;
      end
      FC: begin
        op_b_nxt  = bus.mem_rdata;
        addr      = PC + 8'd2;
        rd        = 1'b1;
        state_nxt = RA;
      end
      RA: begin
        op_c_nxt  = bus.mem_rdata;
        addr      = op_a;
        rd        = 1'b1;
        state_nxt = RB;
      end
      RB: begin
        val_a_nxt = bus.mem_rdata;
        addr      = op_b;
        rd        = 1'b1;
        state_nxt = EX;
      end
      EX: begin
        addr = op_b;
        wr   = 1'b1;
        if (taken) begin
          pc_nxt = op_c;
          // A taken branch to FF is the program's way of terminating.
          if (op_c == 8'hFF) begin
            halt_nxt  = 1'b1;
            state_nxt = HLT;
          end else begin
            state_nxt = FA;
          end
        end else begin
          pc_nxt    = PC + 8'd3;
          state_nxt = FA;
        end
      end
      HLT: begin
        addr      = PC;
        state_nxt = HLT;
      end
      default: begin
        state_nxt = FA;
      end
    endcase
  end

  // Strobes are also masked by RST so an abort mid-EX cannot land a write.
  assign bus.mem_addr  = addr;
  assign bus.mem_re    = rd & EN & ~RST;
  assign bus.mem_we    = wr & EN & ~RST;
  assign bus.mem_wdata = (state == EX) ? diff : 8'h00;

endmodule
